// File: rtl/axis_frame_gen_check_v2_if.sv
// AXI-Stream bus used by the frame generator/checker: one direction per instance,
// master modport for the sender and slave modport for the receiver.
interface axis_frame_gen_check_v2_if #(
    parameter int DATA_WIDTH    = 256,
    parameter int PLEN_WIDTH    = 14,
    parameter int INPORT_WIDTH  = 3,
    parameter int OUTPORT_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [PLEN_WIDTH-1:0]   tuser_packet_length;
    logic [INPORT_WIDTH-1:0] tuser_in_port;
    logic [OUTPORT_WIDTH-1:0] tuser_out_port;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (
        output tdata, tkeep, tuser_packet_length, tuser_in_port, tuser_out_port,
        output tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser_packet_length, tuser_in_port, tuser_out_port,
        input  tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/axis_frame_gen_check_v2.sv
// AXI-Stream frame generator with swept lengths plus an always-ready checker that
// replays the same LFSR/length sequence and counts mismatching beats.
module axis_frame_gen_check_v2 #(
    parameter int          C_PORT_NUMBER         = 0,
    parameter int          C_INPORT_WIDTH        = 3,
    parameter int          C_OUTPORT_WIDTH       = 8,
    parameter int          C_PACKET_LENGTH_WIDTH = 14,
    parameter int          C_AXIS_DATA_WIDTH     = 256,
    parameter int          C_MIN_LEN             = 64,
    parameter int          C_MAX_LEN             = 1518,
    parameter logic [15:0] C_SEED                = 16'hABCD,
    parameter int          C_CNT_WIDTH           = 16
) (
    input  logic                       axi_aclk,
    input  logic                       axi_resetn,
    input  logic                       enable,
    axis_frame_gen_check_v2_if.master  m_axis,
    axis_frame_gen_check_v2_if.slave   s_axis,
    output logic [C_CNT_WIDTH-1:0]     tx_frame_count,
    output logic [C_CNT_WIDTH-1:0]     rx_frame_count,
    output logic [C_CNT_WIDTH-1:0]     error_count,
    output logic                       error
);
    localparam int BYTES = C_AXIS_DATA_WIDTH / 8;
    localparam int PLW   = C_PACKET_LENGTH_WIDTH;
    localparam int CW    = C_CNT_WIDTH;
    localparam int REP   = C_AXIS_DATA_WIDTH / 16;
    localparam logic [PLW-1:0] P_MIN   = PLW'(C_MIN_LEN);
    localparam logic [PLW-1:0] P_MAX   = PLW'(C_MAX_LEN);
    localparam logic [PLW-1:0] P_BYTES = PLW'(BYTES);

    function automatic logic [15:0] f_lfsr_step(input logic [15:0] s);
        return {s[14:0], ~(s[15] ^ s[13] ^ s[12] ^ s[10])};
    endfunction

    function automatic logic [PLW-1:0] f_len_step(input logic [PLW-1:0] l);
        return (l == P_MAX) ? P_MIN : l + PLW'(1);
    endfunction

    // Beats are tracked as bytes remaining in the frame; keep is "byte index < remaining".
    function automatic logic [BYTES-1:0] f_keep(input logic [PLW-1:0] rem);
        logic [BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < BYTES; i++) k[i] = (int'(rem) > i);
        return k;
    endfunction

    function automatic logic f_last(input logic [PLW-1:0] rem);
        return (rem <= P_BYTES);
    endfunction

    // Reset asserts asynchronously and releases two clocks later, on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) r_rst_sync <= 2'b00;
        else             r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // ---------------- generator ----------------
    typedef enum logic {G_IDLE, G_SEND} gen_state_t;

    gen_state_t       r_gstate, w_gstate_next;
    logic [15:0]      r_glfsr, w_glfsr_next;
    logic [PLW-1:0]   r_glen, w_glen_next;
    logic [PLW-1:0]   r_grem, w_grem_next;
    logic [BYTES-1:0] r_gkeep, w_gkeep_next;
    logic             r_glast, w_glast_next;
    logic             r_gvalid, w_gvalid_next;
    logic [CW-1:0]    r_tx_cnt, w_tx_cnt_next;
    logic             w_ghs;

    always_ff @(posedge axi_aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_gstate <= G_IDLE;
            r_glfsr  <= C_SEED;
            r_glen   <= P_MIN;
            r_grem   <= P_MIN;
            r_gkeep  <= '0;
            r_glast  <= 1'b0;
            r_gvalid <= 1'b0;
            r_tx_cnt <= '0;
        end else begin
            r_gstate <= w_gstate_next;
            r_glfsr  <= w_glfsr_next;
            r_glen   <= w_glen_next;
            r_grem   <= w_grem_next;
            r_gkeep  <= w_gkeep_next;
            r_glast  <= w_glast_next;
            r_gvalid <= w_gvalid_next;
            r_tx_cnt <= w_tx_cnt_next;
        end
    end

    // r_grem always describes the beat about to be presented, so idle->send only loads keep/last.
    always_comb begin
        w_gstate_next = r_gstate;
        w_glfsr_next  = r_glfsr;
        w_glen_next   = r_glen;
        w_grem_next   = r_grem;
        w_gkeep_next  = r_gkeep;
        w_glast_next  = r_glast;
        w_gvalid_next = r_gvalid;
        w_tx_cnt_next = r_tx_cnt;
        w_ghs         = r_gvalid & m_axis.tready;
        unique case (r_gstate)
            G_IDLE: begin
                if (enable) begin
                    w_gstate_next = G_SEND;
                    w_gvalid_next = 1'b1;
                    w_gkeep_next  = f_keep(r_grem);
                    w_glast_next  = f_last(r_grem);
                end
            end
            G_SEND: begin
                if (w_ghs) begin
                    w_glfsr_next = f_lfsr_step(r_glfsr);
                    if (r_glast) begin
                        w_tx_cnt_next = r_tx_cnt + CW'(1);
                        w_glen_next   = f_len_step(r_glen);
                        w_grem_next   = w_glen_next;
                    end else begin
                        w_grem_next   = r_grem - P_BYTES;
                    end
                    w_gkeep_next = f_keep(w_grem_next);
                    w_glast_next = f_last(w_grem_next);
                    if (r_glast && !enable) begin
                        w_gstate_next = G_IDLE;
                        w_gvalid_next = 1'b0;
                        w_glast_next  = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign m_axis.tdata               = {REP{r_glfsr}};
    assign m_axis.tkeep               = r_gkeep;
    assign m_axis.tuser_packet_length = r_glen;
    assign m_axis.tuser_in_port       = C_INPORT_WIDTH'(C_PORT_NUMBER);
    assign m_axis.tuser_out_port      = '0;
    assign m_axis.tvalid              = r_gvalid;
    assign m_axis.tlast               = r_glast;
    assign tx_frame_count             = r_tx_cnt;

    // ---------------- checker ----------------
    logic [15:0]              r_clfsr;
    logic [PLW-1:0]           r_clen;
    logic [PLW-1:0]           r_crem;
    logic [CW-1:0]            r_rx_cnt;
    logic [CW-1:0]            r_err_cnt;
    logic                     r_error;
    logic                     r_s_tready;
    logic                     w_beat;
    logic                     w_beat_err;
    logic                     w_close;
    logic                     w_exp_last;
    logic [BYTES-1:0]         w_exp_keep;
    logic [C_AXIS_DATA_WIDTH-1:0] w_exp_data;
    logic [C_AXIS_DATA_WIDTH-1:0] w_byte_mask;

    assign w_exp_keep = f_keep(r_crem);
    assign w_exp_last = f_last(r_crem);
    assign w_exp_data = {REP{r_clfsr}};

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_mask
            assign w_byte_mask[gi*8 +: 8] = {8{w_exp_keep[gi]}};
        end
    endgenerate

    assign w_beat     = s_axis.tvalid & r_s_tready;
    assign w_beat_err = (|((s_axis.tdata ^ w_exp_data) & w_byte_mask))
                      | (s_axis.tkeep != w_exp_keep)
                      | (s_axis.tlast != w_exp_last)
                      | (s_axis.tuser_packet_length != r_clen);
    // A frame closes on whichever arrives first: received tlast or the expected last beat.
    assign w_close    = s_axis.tlast | w_exp_last;

    always_ff @(posedge axi_aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_clfsr    <= C_SEED;
            r_clen     <= P_MIN;
            r_crem     <= P_MIN;
            r_rx_cnt   <= '0;
            r_err_cnt  <= '0;
            r_error    <= 1'b0;
            r_s_tready <= 1'b0;
        end else begin
            r_s_tready <= 1'b1;
            r_error    <= w_beat & w_beat_err;
            if (w_beat) begin
                r_clfsr <= f_lfsr_step(r_clfsr);
                if (w_close) begin
                    r_rx_cnt <= r_rx_cnt + CW'(1);
                    r_clen   <= f_len_step(r_clen);
                    r_crem   <= f_len_step(r_clen);
                end else begin
                    r_crem   <= r_crem - P_BYTES;
                end
                if (w_beat_err && (r_err_cnt != {CW{1'b1}}))
                    r_err_cnt <= r_err_cnt + CW'(1);
            end
        end
    end

    assign s_axis.tready  = r_s_tready;
    assign rx_frame_count = r_rx_cnt;
    assign error_count    = r_err_cnt;
    assign error          = r_error;
endmodule

// File: tb/tb_axis_frame_gen_check_v2.sv
// Loopback bench: generator output is compared against a frame-level model, and the
// checker is exercised with injected data, tlast and saturation faults.
module tb_axis_frame_gen_check_v2;
    localparam int W   = 256;
    localparam int NB  = W / 8;
    localparam int PLW = 14;
    localparam int MIN = 64;
    localparam int MAX = 66;
    localparam logic [W-1:0] FLIP = 256'h80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, tb_enable, tb_ready, tb_flip, tb_kill, tb_zero;
    logic [15:0] tx_a, rx_a, err_a;
    logic        error_a;
    logic [3:0]  tx_b, rx_b, err_b;
    logic        error_b;

    axis_frame_gen_check_v2_if #(.DATA_WIDTH(W), .PLEN_WIDTH(PLW), .INPORT_WIDTH(3), .OUTPORT_WIDTH(8)) m_a ();
    axis_frame_gen_check_v2_if #(.DATA_WIDTH(W), .PLEN_WIDTH(PLW), .INPORT_WIDTH(3), .OUTPORT_WIDTH(8)) s_a ();
    axis_frame_gen_check_v2_if #(.DATA_WIDTH(W), .PLEN_WIDTH(PLW), .INPORT_WIDTH(3), .OUTPORT_WIDTH(8)) m_b ();
    axis_frame_gen_check_v2_if #(.DATA_WIDTH(W), .PLEN_WIDTH(PLW), .INPORT_WIDTH(3), .OUTPORT_WIDTH(8)) s_b ();

    assign m_a.tready              = tb_ready;
    assign s_a.tdata               = tb_flip ? (m_a.tdata ^ FLIP) : m_a.tdata;
    assign s_a.tkeep               = m_a.tkeep;
    assign s_a.tuser_packet_length = m_a.tuser_packet_length;
    assign s_a.tuser_in_port       = m_a.tuser_in_port;
    assign s_a.tuser_out_port      = m_a.tuser_out_port;
    assign s_a.tvalid              = m_a.tvalid & m_a.tready;
    assign s_a.tlast               = m_a.tlast & ~tb_kill;

    assign m_b.tready              = 1'b1;
    assign s_b.tdata               = tb_zero ? '0 : m_b.tdata;
    assign s_b.tkeep               = m_b.tkeep;
    assign s_b.tuser_packet_length = m_b.tuser_packet_length;
    assign s_b.tuser_in_port       = m_b.tuser_in_port;
    assign s_b.tuser_out_port      = m_b.tuser_out_port;
    assign s_b.tvalid              = m_b.tvalid;
    assign s_b.tlast               = m_b.tlast;

    axis_frame_gen_check_v2 #(
        .C_PORT_NUMBER(5), .C_INPORT_WIDTH(3), .C_OUTPORT_WIDTH(8), .C_PACKET_LENGTH_WIDTH(PLW),
        .C_AXIS_DATA_WIDTH(W), .C_MIN_LEN(MIN), .C_MAX_LEN(MAX), .C_SEED(16'hABCD), .C_CNT_WIDTH(16)
    ) dut_a (
        .axi_aclk(clk), .axi_resetn(rst_n), .enable(tb_enable),
        .m_axis(m_a), .s_axis(s_a),
        .tx_frame_count(tx_a), .rx_frame_count(rx_a), .error_count(err_a), .error(error_a)
    );

    axis_frame_gen_check_v2 #(
        .C_PORT_NUMBER(0), .C_INPORT_WIDTH(3), .C_OUTPORT_WIDTH(8), .C_PACKET_LENGTH_WIDTH(PLW),
        .C_AXIS_DATA_WIDTH(W), .C_MIN_LEN(MIN), .C_MAX_LEN(MAX), .C_SEED(16'hABCD), .C_CNT_WIDTH(4)
    ) dut_b (
        .axi_aclk(clk), .axi_resetn(rst_n), .enable(tb_enable),
        .m_axis(m_b), .s_axis(s_b),
        .tx_frame_count(tx_b), .rx_frame_count(rx_b), .error_count(err_b), .error(error_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int pulses_a = 0;
    logic [15:0]  mdl_lfsr;
    int           mdl_frame, mdl_beat;
    bit           prev_stall, bubble_chk;
    logic [319:0] prev_snap, cur_snap;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ~(s[15] ^ s[13] ^ s[12] ^ s[10])};
    endfunction

    task automatic model_reset();
        mdl_lfsr   = 16'hABCD;
        mdl_frame  = 0;
        mdl_beat   = 0;
        prev_stall = 1'b0;
    endtask

    // Called at a falling edge: checks what the generator presents, then advances one clock.
    task automatic tick(input bit rdy);
        int len, nbeats, rem;
        logic [NB-1:0] exp_keep;
        tb_ready = rdy;
        cur_snap = {16'h0, m_a.tdata, m_a.tkeep, m_a.tuser_packet_length, m_a.tlast, m_a.tvalid};
        if (prev_stall) chk("stall_hold", cur_snap, prev_snap);
        if (bubble_chk) chk("no_bubble", 320'(m_a.tvalid), 320'(1));
        if (m_a.tvalid && rdy) begin
            len    = MIN + (mdl_frame % (MAX - MIN + 1));
            nbeats = (len + NB - 1) / NB;
            rem    = len - NB * mdl_beat;
            exp_keep = (rem >= NB) ? '1 : ((32'h1 << rem) - 32'h1);
            chk("gen_tdata", 320'(m_a.tdata), 320'({16{mdl_lfsr}}));
            chk("gen_tkeep", 320'(m_a.tkeep), 320'(exp_keep));
            chk("gen_tlast", 320'(m_a.tlast), 320'(mdl_beat == nbeats - 1));
            chk("gen_plen", 320'(m_a.tuser_packet_length), 320'(len));
            mdl_lfsr = lfsr_step(mdl_lfsr);
            mdl_beat++;
            if (mdl_beat == nbeats) begin
                mdl_beat = 0;
                mdl_frame++;
            end
        end
        prev_stall = m_a.tvalid && !rdy;
        prev_snap  = cur_snap;
        @(posedge clk);
        @(negedge clk);
        if (error_a) pulses_a++;
    endtask

    task automatic run_to_frame(input int target, input bit random_ready);
        for (int g = 0; g < 20000 && mdl_frame < target; g++)
            tick(random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        chk("frames_reached", 320'(mdl_frame), 320'(target));
    endtask

    initial begin
        int f;
        rst_n = 1'b0; tb_enable = 1'b0; tb_ready = 1'b0;
        tb_flip = 1'b0; tb_kill = 1'b0; tb_zero = 1'b0; bubble_chk = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_tvalid", 320'(m_a.tvalid), 320'(0));
        chk("rst_tlast", 320'(m_a.tlast), 320'(0));
        chk("rst_s_tready", 320'(s_a.tready), 320'(0));
        chk("rst_tx", 320'(tx_a), 320'(0));
        chk("rst_rx", 320'(rx_a), 320'(0));
        chk("rst_err", 320'(err_a), 320'(0));
        chk("rst_error", 320'(error_a), 320'(0));
        chk("in_port", 320'(m_a.tuser_in_port), 320'(5));
        chk("out_port", 320'(m_a.tuser_out_port), 320'(0));

        // Loopback, always ready, 300 frames
        rst_n = 1'b1;
        tb_enable = 1'b1;
        for (int i = 0; i < 20 && !m_a.tvalid; i++) tick(1'b1);
        chk("start_valid", 320'(m_a.tvalid), 320'(1));
        chk("first_plen", 320'(m_a.tuser_packet_length), 320'(64));
        chk("first_data", 320'(m_a.tdata), 320'({16{16'hABCD}}));
        chk("s_tready_up", 320'(s_a.tready), 320'(1));
        bubble_chk = 1'b1;
        run_to_frame(300, 1'b0);
        chk("A_tx", 320'(tx_a), 320'(300));
        chk("A_rx", 320'(rx_a), 320'(300));
        chk("A_err", 320'(err_a), 320'(0));
        chk("A_pulses", 320'(pulses_a), 320'(0));

        // Random backpressure
        run_to_frame(450, 1'b1);
        chk("B_tx", 320'(tx_a), 320'(450));
        chk("B_rx", 320'(rx_a), 320'(450));
        chk("B_err", 320'(err_a), 320'(0));

        // Flip tdata bit 7 on one beat
        tb_flip = 1'b1;
        tick(1'b1);
        tb_flip = 1'b0;
        run_to_frame(mdl_frame + 20, 1'b0);
        chk("flip_err", 320'(err_a), 320'(1));
        chk("flip_pulses", 320'(pulses_a), 320'(1));
        chk("flip_rx_eq_tx", 320'(rx_a), 320'(tx_a));

        // Suppress tlast on one expected last beat
        for (int i = 0; i < 8 && !(m_a.tvalid && m_a.tlast); i++) tick(1'b1);
        chk("kill_found", 320'(m_a.tlast), 320'(1));
        tb_kill = 1'b1;
        tick(1'b1);
        tb_kill = 1'b0;
        chk("kill_rx_eq_tx", 320'(rx_a), 320'(tx_a));
        run_to_frame(mdl_frame + 20, 1'b0);
        chk("kill_err", 320'(err_a), 320'(2));
        chk("kill_pulses", 320'(pulses_a), 320'(2));
        chk("kill_rx_eq_tx_later", 320'(rx_a), 320'(tx_a));

        // 4-bit error counter saturation
        chk("sat_pre", 320'(err_b), 320'(0));
        tb_zero = 1'b1;
        repeat (40) tick(1'b1);
        tb_zero = 1'b0;
        repeat (10) tick(1'b1);
        chk("sat_err", 320'(err_b), 320'(15));

        // Enable dropped mid-frame: the frame completes, then the generator idles
        bubble_chk = 1'b0;
        for (int i = 0; i < 4 && m_a.tlast; i++) tick(1'b1);
        chk("mid_frame", 320'(m_a.tlast), 320'(0));
        tb_enable = 1'b0;
        f = mdl_frame;
        for (int i = 0; i < 10 && mdl_frame == f; i++) tick(1'b1);
        chk("drain_done", 320'(mdl_frame), 320'(f + 1));
        for (int i = 0; i < 4; i++) begin
            chk("idle_tvalid", 320'(m_a.tvalid), 320'(0));
            chk("idle_tlast", 320'(m_a.tlast), 320'(0));
            tick(1'b1);
        end
        chk("drain_tx", 320'(tx_a), 320'(f + 1));
        chk("drain_rx", 320'(rx_a), 320'(f + 1));

        // Reset asserted mid-frame
        tb_enable = 1'b1;
        for (int i = 0; i < 10 && mdl_beat != 1; i++) tick(1'b1);
        chk("reset_mid_frame", 320'(mdl_beat), 320'(1));
        rst_n = 1'b0;
        #1;
        chk("rst2_tvalid", 320'(m_a.tvalid), 320'(0));
        chk("rst2_tlast", 320'(m_a.tlast), 320'(0));
        chk("rst2_tx", 320'(tx_a), 320'(0));
        chk("rst2_rx", 320'(rx_a), 320'(0));
        chk("rst2_err", 320'(err_a), 320'(0));
        chk("rst2_err_b", 320'(err_b), 320'(0));
        model_reset();
        @(negedge clk);
        tick(1'b1);
        tick(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 20 && !m_a.tvalid; i++) tick(1'b1);
        chk("post_rst_valid", 320'(m_a.tvalid), 320'(1));
        chk("post_rst_plen", 320'(m_a.tuser_packet_length), 320'(64));
        chk("post_rst_data", 320'(m_a.tdata), 320'({16{16'hABCD}}));
        run_to_frame(3, 1'b0);
        chk("post_rst_tx", 320'(tx_a), 320'(3));
        chk("post_rst_rx", 320'(rx_a), 320'(3));
        chk("post_rst_err", 320'(err_a), 320'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
